// File: rtl/ariane_bm_crc_unit.sv
// ariane_bm_crc_unit: bit-serial CRC32/CRC32C bitmanip unit; CRC32C enabled by ARIANE_BM_CRCC_EN
module ariane_bm_crc_unit #(
  parameter int XLEN          = 64,
  parameter int TRANS_ID_BITS = 3
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     flush_i,
  input  logic                     valid_i,
  output logic                     ready_o,
  input  logic [8:0]               operator_i,
  input  logic [XLEN-1:0]          operand_a_i,
  input  logic [TRANS_ID_BITS-1:0] trans_id_i,
  output logic [XLEN-1:0]          result_o,
  output logic                     result_valid_o,
  output logic [TRANS_ID_BITS-1:0] result_trans_id_o,
  output logic                     exception_o
);
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] BUSY = 2'd1;
  localparam logic [1:0] DONE = 2'd2;
  localparam logic [XLEN-1:0] P_CRC  = XLEN'(32'hEDB88320);
  logic [1:0]               state;
  logic [XLEN-1:0]          x;
  logic [XLEN-1:0]          x_nxt;
  logic [XLEN-1:0]          poly;
  logic [6:0]               cnt;
  logic [6:0]               n_m1;
  logic [TRANS_ID_BITS-1:0] id;
  logic                     skip;
  logic                     unused_op;
`ifdef ARIANE_BM_CRCC_EN
  localparam logic [XLEN-1:0] P_CRCC = XLEN'(32'h82F63B38);
  logic crcc;
  assign poly = crcc ? P_CRCC : P_CRC;
  assign skip = 1'b0;
`else
  assign poly = P_CRC;
  assign skip = operator_i[2];
`endif
  assign unused_op      = ^operator_i[8:3];
  assign ready_o        = state == IDLE;
  assign result_valid_o = state == DONE;
  assign n_m1  = (XLEN == 32 && operator_i[1:0] == 2'b11) ? 7'd31 : (7'd8 << operator_i[1:0]) - 7'd1;
  assign x_nxt = (x >> 1) ^ (x[0] ? poly : '0);
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state             <= IDLE;
      x                 <= '0;
      cnt               <= '0;
      id                <= '0;
      result_o          <= '0;
      result_trans_id_o <= '0;
      exception_o       <= 1'b0;
`ifdef ARIANE_BM_CRCC_EN
      crcc              <= 1'b0;
`endif
    end else if (flush_i) begin
      state <= IDLE;
    end else if (state == IDLE) begin
      if (valid_i && skip) begin
        state             <= DONE;
        result_o          <= '0;
        result_trans_id_o <= trans_id_i;
        exception_o       <= 1'b1;
      end else if (valid_i) begin
        state <= BUSY;
        x     <= operand_a_i;
        cnt   <= n_m1;
        id    <= trans_id_i;
`ifdef ARIANE_BM_CRCC_EN
        crcc  <= operator_i[2];
`endif
      end
    end else if (state == BUSY) begin
      x <= x_nxt;
      if (cnt == 7'd0) begin
        state             <= DONE;
        result_o          <= x_nxt;
        result_trans_id_o <= id;
        exception_o       <= 1'b0;
      end else begin
        cnt <= cnt - 7'd1;
      end
    end else begin
      state <= IDLE;
    end
  end
endmodule

// File: doc/ariane_bm_crc_unit.md
# ariane_bm_crc_unit

Iterative bitmanip CRC execution unit: consumes CRC operations issued with the 9-bit bitmanip function code (CRCB/CRCH/CRCW/CRCD, CRCCB/CRCCH/CRCCW/CRCCD) from the bitmanip issue path, computes the result bit-serially, and returns it with its transaction ID to writeback. It is the consumer side of the bitmanip function-code encoding: the decoder emits the code, and this unit interprets bits [2:0] of it. One bit of CRC state is advanced per cycle, so the unit trades latency for area.

## Interface
- XLEN, 64: datapath width (64 or 32).
- TRANS_ID_BITS, 3: scoreboard transaction ID width.

Ports:
- clk_i in 1: clock.
- rst_i in 1: reset, asynchronous, active-high.
- flush_i in 1: abort any in-flight operation.
- valid_i in 1: operation offered.
- ready_o out 1: unit can accept; high only in IDLE.
- operator_i in 9: bitmanip function code. Bit [2] selects CRC32C (1) or CRC32 (0). Bits [1:0] select the size: 00=b, 01=h, 10=w, 11=d. Bits [8:3] are ignored.
- operand_a_i in XLEN: rs1 value.
- trans_id_i in TRANS_ID_BITS: transaction ID.
- result_o out XLEN: CRC result.
- result_valid_o out 1: single-cycle pulse, no backpressure.
- result_trans_id_o out TRANS_ID_BITS: ID of the returned result.
- exception_o out 1: illegal-operation flag, qualified by result_valid_o.

## Operation
- FSM states: IDLE, BUSY, DONE.
- IDLE -> BUSY when valid_i && ready_o.
  - On acceptance, latch x=operand_a_i, the polynomial, trans_id_i, and N = 8 << size.
  - With XLEN=32, size 11 is treated as N=32.
- BUSY: each cycle, x <= (x >> 1) ^ (x[0] ? P : 0).
  - The shift is a logical right shift of the full XLEN register.
  - P is 0xEDB88320 (CRC32) or 0x82F63B38 (CRC32C), zero-extended to XLEN.
  - A 7-bit counter counts down from N-1. When it reaches 0, after the final update, the FSM moves to DONE.
- DONE: result_valid_o=1, result_o=x, result_trans_id_o = the latched ID, exception_o=0. Next state is IDLE.
- Operand bits above N shift down into the result. The result is not masked to 32 bits.
- Flush: from any state, the next state is IDLE. No result is produced, and a DONE pulse already on the outputs in that cycle is still visible. valid_i in a cycle with flush_i is not accepted.
- Reset mid-operation: the FSM returns to IDLE immediately, and the in-flight result is lost.

## Timing
- Reset values:
  - ready_o=1
  - result_valid_o=0
  - result_o=0
  - result_trans_id_o=0
  - exception_o=0
  - FSM in IDLE, counter=0.
- Latency from the accept edge to the result_valid_o cycle is N+1: 9, 17, 33, or 65 cycles.
- Throughput: a new operation can be accepted in the cycle after DONE, giving an initiation interval of N+2.
- ready_o is a registered-state decode. It has no combinational path from valid_i.
- result_o holds its value after DONE until the next DONE. It is only meaningful while result_valid_o is high.

## Configuration
- ARIANE_BM_CRCC_EN defined: CRC32C operations execute as described above.
- ARIANE_BM_CRCC_EN undefined:
  - The CRC32C polynomial logic is removed.
  - An operation with operator_i[2]=1 is still accepted but skips BUSY: it goes IDLE -> DONE, with result_o=0 and exception_o=1 in the DONE cycle.
  - Latency for this case is 1.

## Test plan
- CRCB (code 9'b000000_0_00), operand 0x01, ID 5: result_valid_o 9 cycles after accept, result 0x77073096, ID 5, exception_o=0.
- CRCB, operand 0xFF: result 0x2D02EF8D. CRCB, operand 0x100: result 0x1, showing that upper operand bits shift into the result.
- CRCCB, operand 0x01: result 0xF26B8303 with ARIANE_BM_CRCC_EN defined. Without the macro, the same operation gives result 0 with exception_o=1, one cycle after accept.
- CRCD, operand 0: ready_o stays low for 65 cycles, result 0 at cycle 65. A valid_i held high during BUSY is accepted only in the cycle after DONE.
- Flush at cycle 10 of a CRCW: no result_valid_o pulse, ready_o=1 the next cycle, and a following CRCB on 0x01 returns 0x77073096.
- rst_i asserted mid-CRCH: all outputs take their reset values asynchronously. After release, CRCB on 0xFF returns 0x2D02EF8D.
